// File: rtl/spi_frame_fsm_if.sv
// spi_frame_fsm_if: conditioned SPI pins from the input conditioner plus the
// register/memory side handshake. The master side is the environment (pin
// conditioner and memory); the slave side is the frame decoder.
interface spi_frame_fsm_if #(
   parameter int ADDRWIDTH = 7,
   parameter int DATAWIDTH = 8
);
   logic                 cs_cond;
   logic                 sclk_posedge;
   logic                 sclk_negedge;
   logic                 mosi_cond;
   logic [DATAWIDTH-1:0] rd_data;
   logic [ADDRWIDTH-1:0] addr;
   logic [DATAWIDTH-1:0] wr_data;
   logic                 wr_en;
   logic                 rd_req;
   logic                 miso;
   logic                 miso_oe;
   logic                 busy;

   modport master (
      output cs_cond, sclk_posedge, sclk_negedge, mosi_cond, rd_data,
      input  addr, wr_data, wr_en, rd_req, miso, miso_oe, busy
   );

   modport slave (
      input  cs_cond, sclk_posedge, sclk_negedge, mosi_cond, rd_data,
      output addr, wr_data, wr_en, rd_req, miso, miso_oe, busy
   );
endinterface

// File: rtl/spi_frame_fsm.sv
// spi_frame_fsm: decodes conditioned SPI frames into an address, a read/write
// bit and a data byte. Writes produce a one-cycle strobe; reads fetch a byte
// from the memory stage and shift it back out on MISO, MSB first.
module spi_frame_fsm #(
   parameter int ADDRWIDTH = 7,
   parameter int DATAWIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   spi_frame_fsm_if.slave bus
);
   // Bits collected before the last bit of a field; the last bit is taken
   // directly from mosi_cond in the cycle the field is latched.
   localparam int         INW       = (ADDRWIDTH > DATAWIDTH - 1) ? ADDRWIDTH : DATAWIDTH - 1;
   localparam logic [3:0] ADDR_LAST = 4'(ADDRWIDTH);
   localparam logic [3:0] DATA_LAST = 4'(DATAWIDTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      WDATA = 3'd2,
      RREQ  = 3'd3,
      RLOAD = 3'd4,
      RDATA = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t               state_r;
   logic [3:0]           cnt_r;
   logic [INW-1:0]       in_r;
   logic [DATAWIDTH-1:0] out_r;
   logic [ADDRWIDTH-1:0] addr_r;
   logic [DATAWIDTH-1:0] wr_data_r;
   logic                 wr_en_r;
   logic                 rd_req_r;
   logic                 miso_r;
   logic                 miso_oe_r;
   logic                 busy_r;

   logic [INW:0]         in_next_s;
   logic [DATAWIDTH-1:0] out_next_s;

   assign in_next_s  = {in_r, bus.mosi_cond};
   assign out_next_s = out_r << 1'b1;

   assign bus.addr    = addr_r;
   assign bus.wr_data = wr_data_r;
   assign bus.wr_en   = wr_en_r;
   assign bus.rd_req  = rd_req_r;
   assign bus.miso    = miso_r;
   assign bus.miso_oe = miso_oe_r;
   assign bus.busy    = busy_r;

   // Frame sequencer: state, bit counter, shift registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= 4'd0;
         in_r      <= {INW{1'b0}};
         out_r     <= {DATAWIDTH{1'b0}};
         addr_r    <= {ADDRWIDTH{1'b0}};
         wr_data_r <= {DATAWIDTH{1'b0}};
         wr_en_r   <= 1'b0;
         rd_req_r  <= 1'b0;
         miso_r    <= 1'b0;
         miso_oe_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-armed below
         wr_en_r  <= 1'b0;
         rd_req_r <= 1'b0;
         if ((state_r != IDLE) && bus.cs_cond) begin
            // Chip select released mid-frame (or at the end of DONE): drop
            // everything in flight but keep the last latched addr/wr_data.
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            in_r      <= {INW{1'b0}};
            out_r     <= {DATAWIDTH{1'b0}};
            miso_r    <= 1'b0;
            miso_oe_r <= 1'b0;
            busy_r    <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (!bus.cs_cond) begin
                     state_r <= ADDR;
                     cnt_r   <= 4'd0;
                     in_r    <= {INW{1'b0}};
                     busy_r  <= 1'b1;
                  end
               end
               ADDR: begin
                  if (bus.sclk_posedge) begin
                     if (cnt_r == ADDR_LAST) begin
                        // Last header bit is rw; the bits before it are the address
                        addr_r <= in_next_s[ADDRWIDTH:1];
                        cnt_r  <= 4'd0;
                        in_r   <= {INW{1'b0}};
                        if (bus.mosi_cond) begin
                           state_r  <= RREQ;
                           rd_req_r <= 1'b1;
                        end else begin
                           state_r <= WDATA;
                        end
                     end else begin
                        in_r  <= in_next_s[INW-1:0];
                        cnt_r <= cnt_r + 4'd1;
                     end
                  end
               end
               WDATA: begin
                  if (bus.sclk_posedge) begin
                     if (cnt_r == DATA_LAST) begin
                        wr_data_r <= in_next_s[DATAWIDTH-1:0];
                        wr_en_r   <= 1'b1;
                        state_r   <= DONE;
                        cnt_r     <= 4'd0;
                        in_r      <= {INW{1'b0}};
                     end else begin
                        in_r  <= in_next_s[INW-1:0];
                        cnt_r <= cnt_r + 4'd1;
                     end
                  end
               end
               RREQ: begin
                  // rd_req is high for exactly this state; memory answers next cycle
                  state_r <= RLOAD;
                  cnt_r   <= 4'd0;
               end
               RLOAD: begin
                  out_r     <= bus.rd_data;
                  miso_r    <= bus.rd_data[DATAWIDTH-1];
                  miso_oe_r <= 1'b1;
                  state_r   <= RDATA;
                  cnt_r     <= 4'd0;
               end
               RDATA: begin
                  if (bus.sclk_negedge) begin
                     if (cnt_r == DATA_LAST) begin
                        miso_r    <= 1'b0;
                        miso_oe_r <= 1'b0;
                        out_r     <= {DATAWIDTH{1'b0}};
                        state_r   <= DONE;
                        cnt_r     <= 4'd0;
                     end else begin
                        out_r  <= out_next_s;
                        miso_r <= out_next_s[DATAWIDTH-1];
                        cnt_r  <= cnt_r + 4'd1;
                     end
                  end
               end
               DONE: begin
                  // Waits for chip select release, handled above
                  cnt_r <= cnt_r;
               end
               default: begin
                  state_r   <= IDLE;
                  cnt_r     <= 4'd0;
                  in_r      <= {INW{1'b0}};
                  out_r     <= {DATAWIDTH{1'b0}};
                  miso_r    <= 1'b0;
                  miso_oe_r <= 1'b0;
                  busy_r    <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: doc/spi_frame_fsm.md
Name: spi_frame_fsm

Overview:
- Consumes the conditioned SPI pins (chip select, MOSI, SCLK edge pulses) from the input-conditioner stage.
- Decodes each frame into an address, a read/write bit and a data byte.
- Write frames produce a one-cycle write strobe toward the register/memory stage.
- Read frames fetch a byte from the memory stage and shift it out on MISO.

Parameters:
- ADDRWIDTH, 7, address bits per frame. ADDRWIDTH+1 must be at most 15.
- DATAWIDTH, 8, data bits per frame. Must be at most 15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cs_cond  input  1  conditioned chip select, active low.
- sclk_posedge  input  1  one-clk pulse on a conditioned SCLK rising edge.
- sclk_negedge  input  1  one-clk pulse on a conditioned SCLK falling edge.
- mosi_cond  input  1  conditioned MOSI level.
- rd_data  input  DATAWIDTH  memory read data; valid the cycle after rd_req.
- addr  output  ADDRWIDTH  latched frame address.
- wr_data  output  DATAWIDTH  latched write data.
- wr_en  output  1  one-cycle write strobe.
- rd_req  output  1  one-cycle read request.
- miso  output  1  serial read data, MSB first.
- miso_oe  output  1  MISO output enable, high only while read data is being driven.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE; addr=0, wr_data=0, wr_en=0, rd_req=0, miso=0, miso_oe=0, busy=0; shift register and bit counter cleared.
- Edge pulses and MOSI are ignored whenever cs_cond=1.
- Bit counter: 4 bits, cleared on every state transition.
- States:
  - IDLE: cs_cond=0 moves to ADDR on the next clk.
  - ADDR: on each sclk_posedge, shift mosi_cond in MSB-first. On the (ADDRWIDTH+1)th posedge:
    - latch addr from the first ADDRWIDTH bits;
    - last bit is rw (1=read, 0=write);
    - rw=0 goes to WDATA, rw=1 goes to RREQ.
  - WDATA: shift mosi_cond in on each sclk_posedge. On the DATAWIDTH-th posedge, latch wr_data; wr_en=1 during the following cycle only; go to DONE.
  - RREQ: rd_req=1 for exactly this one cycle (addr already stable); go to RLOAD.
  - RLOAD: load rd_data into the output shift register; miso=its MSB and miso_oe=1 from the next cycle; go to RDATA.
  - RDATA: on each sclk_negedge, shift left and present the next bit on miso. After DATAWIDTH negedges, miso_oe=0; go to DONE.
  - DONE: ignore all edges until cs_cond=1, then go to IDLE.
- Abort: cs_cond=1 in any non-IDLE state goes to IDLE on the next clk.
  - No wr_en or rd_req is issued after the abort cycle.
  - miso_oe drops and the partial shift contents are discarded.
  - addr and wr_data keep their last latched values.
- Simultaneous cs_cond rise and final sclk_posedge: abort wins; no wr_en.
- Simultaneous sclk_posedge and sclk_negedge: the state's relevant edge is processed and the other is ignored.
- Timing requirement on the environment: at least 3 clk cycles between the final address posedge and the next sclk_negedge, so that RREQ/RLOAD complete before the first data negedge.
- Latency:
  - wr_en is 1 cycle after the final data posedge pulse.
  - First miso bit is 3 cycles after the final address posedge pulse.
- Reset asserted mid-frame: immediate return to the reset values above.

Test Plan:
- Write frame: CS low, send addr 7'h2A, rw=0, data 8'hC3 -> addr=2A; wr_en high exactly one cycle with wr_data=C3; busy high until CS high, then 0.
- Read frame: send addr 7'h05, rw=1; memory returns 8'hA5 the cycle after rd_req -> rd_req pulses once; miso_oe=1; miso shows 1,0,1,0,0,1,0,1 across 8 negedges; miso_oe=0 after the 8th.
- Abort: CS high after 4 data bits of a write -> no wr_en, state returns to IDLE; a following full write to 7'h01 with data 8'h7E completes correctly.
- Collision: CS rises in the same cycle as the 8th data posedge -> wr_en stays 0.
- Edges with CS high: 20 sclk pulses toggling MOSI -> busy, wr_en, rd_req and miso_oe all stay 0.
- Async reset mid-read (rst_n low between clk edges) -> all outputs 0 immediately; the next frame decodes normally.
